// File: rtl/cam2axis.sv
// cam2axis: DVP RGB565 camera capture to 24-bit AXI4-Stream video with frame skip and show-ahead FIFO.
// Optional CAM2AXIS_STAT_EN adds frame_cnt/line_cnt statistics ports.
module cam2axis #(
  parameter int SKIP_FRAMES    = 10,
  parameter int FIFO_DEPTH     = 16,
  parameter int VSYNC_ACT_HIGH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        overflow,
  output logic        odd_err
`ifdef CAM2AXIS_STAT_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [11:0] line_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {WAIT_VS, SKIP, WAIT_FS, ACTIVE, DROP} state_t;
  state_t state, nxt, fs_nxt;
  logic blank, blank_q, href_q, fs, hfall, ph, pend_v, sof, done, push, full, pop, ovf, wr;
  logic [7:0] b0;
  logic [23:0] pend_d, pix;
  logic [15:0] skip;
  logic [25:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign blank = (VSYNC_ACT_HIGH != 0) ? cam_vsync : ~cam_vsync;
  assign fs = blank_q & ~blank;
  assign hfall = href_q & ~cam_href;
  assign done = (state == ACTIVE) && cam_href && ph;
  assign pix = {b0[7:3], b0[7:5], b0[2:0], cam_data[7:5], b0[2:1], cam_data[4:0], cam_data[4:2]};
  assign push = pend_v & (done | hfall);
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign pop = m_axis_tvalid & m_axis_tready;
  assign ovf = push & full & ~pop;
  assign wr = push & ~ovf;
  assign m_axis_tvalid = cnt != '0;
  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = m_axis_tvalid ? mem[rp] : '0;
  // The frame start that exhausts the skip count is itself the first usable frame start.
  always_comb begin
    fs_nxt = enable ? ACTIVE : WAIT_FS;
    nxt = state;
    if (fs && state == WAIT_VS) nxt = (SKIP_FRAMES == 0) ? fs_nxt : SKIP;
    else if (fs && state == SKIP) nxt = (skip == 16'd1) ? fs_nxt : SKIP;
    else if (fs) nxt = fs_nxt;
    else if (ovf) nxt = DROP;
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= WAIT_VS;
    else state <= nxt;
  always_ff @(posedge clk)
    if (wr) mem[wp] <= {sof, hfall, pend_d};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blank_q  <= 1'b0;
      href_q   <= 1'b0;
      ph       <= 1'b0;
      pend_v   <= 1'b0;
      sof      <= 1'b0;
      skip     <= '0;
      b0       <= '0;
      pend_d   <= '0;
      overflow <= 1'b0;
      odd_err  <= 1'b0;
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
    end else begin
      blank_q  <= blank;
      href_q   <= cam_href;
      skip     <= (fs && state == WAIT_VS) ? 16'(SKIP_FRAMES) : (fs && state == SKIP) ? skip - 16'd1 : skip;
      ph       <= (fs || hfall) ? 1'b0 : (state == ACTIVE && cam_href) ? ~ph : ph;
      if (state == ACTIVE && cam_href && !ph) b0 <= cam_data;
      if (done) pend_d <= pix;
      pend_v   <= (fs || hfall || ovf) ? 1'b0 : done ? 1'b1 : pend_v;
      sof      <= (fs && nxt == ACTIVE) ? 1'b1 : wr ? 1'b0 : sof;
      overflow <= overflow | ovf;
      odd_err  <= odd_err | (hfall && ph && state == ACTIVE);
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt      <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end
`ifdef CAM2AXIS_STAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      line_cnt  <= '0;
    end else begin
      if (wr && sof) frame_cnt <= frame_cnt + 16'd1;
      line_cnt <= fs ? '0 : (wr && hfall) ? line_cnt + 12'd1 : line_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_cam2axis.sv
// tb_cam2axis: scoreboard bench for cam2axis driving DVP frames built from a pixel vector table.
module tb_cam2axis;
  logic clk = 0, rst_n = 0, enable = 1, cam_vsync = 0, cam_href = 0, tready = 1;
  logic [7:0] cam_data = 0;
  logic [23:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tuser, m_axis_tlast, overflow, odd_err;
`ifdef CAM2AXIS_STAT_EN
  logic [15:0] frame_cnt;
  logic [11:0] line_cnt;
`endif
  cam2axis #(.SKIP_FRAMES(2), .FIFO_DEPTH(16), .VSYNC_ACT_HIGH(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(tready), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .overflow(overflow), .odd_err(odd_err)
`ifdef CAM2AXIS_STAT_EN
    , .frame_cnt(frame_cnt), .line_cnt(line_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {logic [7:0] b0; logic [7:0] b1; logic [23:0] px;} vec_t;
  vec_t tbl[8];
  logic [25:0] q[$];
  int total = 0, bad = 0, beats = 0, k = 0, flim = 0;
  bit fexp = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask
  always @(negedge clk)
    if (rst_n && m_axis_tvalid && tready) begin
      beats++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got %0h want none", {m_axis_tuser, m_axis_tlast, m_axis_tdata});
      end else chk("beat", {6'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {6'd0, q.pop_front()});
    end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic line(input int nb, input int rst_at);
    repeat (3) step;
    for (int i = 0; i < nb; i++) begin
      cam_href = 1;
      cam_data = (i % 2) ? tbl[(i/2)%8].b1 : tbl[(i/2)%8].b0;
      rst_n = (i != rst_at);
      if (i == rst_at) begin
        q.delete();
        fexp = 0;
      end
      if ((i % 2) && fexp && k < flim) q.push_back({k == 0, i/2 == nb/2 - 1, tbl[(i/2)%8].px});
      if (i % 2) k++;
      step;
      if (i == rst_at) begin
        chk("rst_tvalid", {31'd0, m_axis_tvalid}, 0);
        chk("rst_flags", {30'd0, overflow, odd_err}, 0);
      end
    end
    cam_href = 0;
    rst_n = 1;
    repeat (3) step;
  endtask
  task automatic vs_start(input bit e, input int lim);
    cam_vsync = 1;
    repeat (4) step;
    cam_vsync = 0;
    fexp = e;
    flim = lim;
    k = 0;
  endtask
  task automatic frame(input int nl, input int nb, input bit e, input int lim);
    vs_start(e, lim);
    for (int l = 0; l < nl; l++) line(nb, -1);
  endtask
  task automatic drain(input string nm);
    for (int i = 0; i < 300 && q.size() > 0; i++) step;
    repeat (3) step;
    chk(nm, q.size(), 0);
  endtask
  initial begin
    tbl[0] = '{8'hF8, 8'h1F, 24'hFF00FF};
    tbl[1] = '{8'h07, 8'hE0, 24'h00FF00};
    tbl[2] = '{8'h00, 8'h00, 24'h000000};
    tbl[3] = '{8'hFF, 8'hFF, 24'hFFFFFF};
    tbl[4] = '{8'h08, 8'h00, 24'h080000};
    tbl[5] = '{8'h00, 8'h01, 24'h000008};
    tbl[6] = '{8'h00, 8'h20, 24'h000400};
    tbl[7] = '{8'h84, 8'h10, 24'h848284};
    repeat (3) step;
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 0);
    chk("rst_tdata", {8'd0, m_axis_tdata}, 0);
    chk("rst_tuser_tlast", {30'd0, m_axis_tuser, m_axis_tlast}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    chk("rst_odd_err", {31'd0, odd_err}, 0);
    rst_n = 1;
    step;
    chk("release_tvalid", {31'd0, m_axis_tvalid}, 0);
    beats = 0;
    frame(4, 16, 0, 0);
    frame(4, 16, 0, 0);
    chk("skip_beats", beats, 0);
    frame(4, 16, 1, 9999);
    drain("frame3_drain");
    chk("frame3_beats", beats, 32);
    tready = 0;
    frame(1, 128, 1, 16);
    chk("overflow_set", {31'd0, overflow}, 1);
    chk("stall_head", {6'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {6'd0, q[0]});
    tready = 1;
    drain("overflow_drain");
    frame(1, 16, 1, 9999);
    drain("post_overflow_drain");
    chk("overflow_sticky", {31'd0, overflow}, 1);
    chk("odd_clear", {31'd0, odd_err}, 0);
    frame(2, 9, 1, 9999);
    drain("odd_drain");
    chk("odd_err_set", {31'd0, odd_err}, 1);
    enable = 0;
    beats = 0;
    frame(2, 16, 0, 0);
    enable = 1;
    chk("disabled_beats", beats, 0);
    vs_start(1, 9999);
    line(16, 9);
    line(16, -1);
    beats = 0;
    frame(4, 16, 0, 0);
    frame(4, 16, 0, 0);
    chk("post_rst_skip_beats", beats, 0);
    frame(4, 16, 1, 9999);
    frame(4, 16, 1, 9999);
    frame(4, 16, 1, 9999);
    drain("post_rst_drain");
    chk("post_rst_beats", beats, 96);
`ifdef CAM2AXIS_STAT_EN
    chk("frame_cnt", {16'd0, frame_cnt}, 3);
    chk("line_cnt", {20'd0, line_cnt}, 4);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
